motion_cmd_scheduler: RTL and testbench

- Sequences the rojobot `motion_mode` bus, which drives the motor model and the compass heading indicator.
- Accepts timed motion commands (mode + duration) from two requesters: manual pushbutton decoder (M) and autonomous script engine (A).
- Round-robin arbitration between M and A feeds a small command FIFO.
- Each queued command is executed for an exact number of 10 Hz ticks; output is STOP when idle.

---
 rtl/motion_pkg.sv | 27 ++
 rtl/motion_cmd_fifo.sv | 62 ++++++
 rtl/motion_cmd_scheduler.sv | 162 ++++++++++++++++
 tb/tb_motion_cmd_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared definitions for the rojobot motion command scheduler: mode encodings,
// the queued command record, scheduler states and mode sanitising.
package motion_pkg;

   localparam int CMD_DUR_W = 8;

   localparam logic [2:0] STOP = 3'b000;
   localparam logic [2:0] R_1X = 3'b001;
   localparam logic [2:0] R_2X = 3'b010;
   localparam logic [2:0] L_1X = 3'b011;
   localparam logic [2:0] L_2X = 3'b100;
   localparam logic [2:0] FWD  = 3'b101;
   localparam logic [2:0] REV  = 3'b110;

   typedef struct packed {
      logic [2:0]           mode;
      logic [CMD_DUR_W-1:0] dur;
   } motion_cmd_t;

   typedef enum logic {IDLE, RUN} sched_state_t;

   // 3'b111 has no meaning on the motion bus, so it is parked as STOP
   function automatic logic [2:0] clean_mode(input logic [2:0] mode);
      return (mode == 3'b111) ? STOP : mode;
   endfunction

endpackage

// File: rtl/motion_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO; head shows the oldest entry while not empty.
// A flush empties it on the next edge regardless of push/pop.
module motion_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 11
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign level = count;

endmodule

// File: rtl/motion_cmd_scheduler.sv
// Arbitrates manual/autonomous timed motion commands into a FIFO and plays them
// on motion_mode for whole 10 Hz ticks. Optional macro MOTION_SCHED_ABORT_EN adds a sync abort.
module motion_cmd_scheduler
   import motion_pkg::*;
#(
   parameter int TICK_MAX = 9_999_999,
   parameter int DEPTH    = 4,
   parameter int DUR_W    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
`ifdef MOTION_SCHED_ABORT_EN
   input  logic                   abort,
`endif
   input  logic                   m_valid,
   input  logic [2:0]             m_mode,
   input  logic [DUR_W-1:0]       m_dur,
   output logic                   m_ready,
   input  logic                   a_valid,
   input  logic [2:0]             a_mode,
   input  logic [DUR_W-1:0]       a_dur,
   output logic                   a_ready,
   output logic [2:0]             motion_mode,
   output logic                   busy,
   output logic                   cmd_done,
   output logic [$clog2(DEPTH):0] level
);

   localparam int CMD_W = 3 + DUR_W;
   localparam int DIV_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(TICK_MAX);

   sched_state_t     state_q, state_d;
   logic [2:0]       mode_q, mode_d;
   logic [DUR_W-1:0] remain_q, remain_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             done_q, done_d;
   logic             favour_m;
   logic             abort_now;

   logic             push, pop, full, empty;
   logic [CMD_W-1:0] push_data, head;
   logic [2:0]       head_mode;
   logic [DUR_W-1:0] head_dur;

`ifdef MOTION_SCHED_ABORT_EN
   assign abort_now = abort;
`else
   assign abort_now = 1'b0;
`endif

   // Grants look only at the registered full flag, so a same-cycle pop never frees a slot
   always_comb begin
      m_ready = 1'b0;
      a_ready = 1'b0;
      if (!full && !abort_now) begin
         m_ready = m_valid & (~a_valid | favour_m);
         a_ready = a_valid & ~m_ready;
      end
   end

   assign push      = m_ready | a_ready;
   assign push_data = m_ready ? {clean_mode(m_mode), m_dur} : {clean_mode(a_mode), a_dur};
   assign head_mode = head[CMD_W-1 -: 3];
   assign head_dur  = head[DUR_W-1:0];

   motion_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (abort_now),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   // Zero-duration entries are discarded in IDLE; the last tick of a command
   // chains straight into a valid head so the motor never sees a STOP gap
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      remain_d = remain_q;
      div_d    = div_q;
      done_d   = 1'b0;
      pop      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (head_dur != '0) begin
                  state_d  = RUN;
                  mode_d   = head_mode;
                  remain_d = head_dur;
                  div_d    = '0;
               end
            end
         end
         RUN: begin
            if (div_q == DIV_TERM) begin
               div_d = '0;
               if (remain_q > DUR_W'(1)) begin
                  remain_d = remain_q - 1'b1;
               end else begin
                  done_d = 1'b1;
                  if (!empty && head_dur != '0) begin
                     pop      = 1'b1;
                     mode_d   = head_mode;
                     remain_d = head_dur;
                  end else begin
                     mode_d  = STOP;
                     state_d = IDLE;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort_now) begin
         state_d  = IDLE;
         mode_d   = STOP;
         remain_d = '0;
         div_d    = '0;
         done_d   = 1'b0;
         pop      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         mode_q   <= STOP;
         remain_q <= '0;
         div_q    <= '0;
         done_q   <= 1'b0;
         favour_m <= 1'b1;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         remain_q <= remain_d;
         div_q    <= div_d;
         done_q   <= done_d;
         if (m_ready) begin
            favour_m <= 1'b0;
         end else if (a_ready) begin
            favour_m <= 1'b1;
         end
      end
   end

   assign motion_mode = mode_q;
   assign busy        = (state_q == RUN);
   assign cmd_done    = done_q;

endmodule

// File: tb/tb_motion_cmd_scheduler.sv
// Self-checking bench for motion_cmd_scheduler: queue/countdown reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_motion_cmd_scheduler;
   import motion_pkg::*;

   localparam int TICK_MAX = 4;
   localparam int DEPTH    = 4;
   localparam int DUR_W    = 8;
   localparam int PER      = TICK_MAX + 1;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   m_valid = 1'b0;
   logic [2:0]             m_mode = '0;
   logic [DUR_W-1:0]       m_dur = '0;
   logic                   a_valid = 1'b0;
   logic [2:0]             a_mode = '0;
   logic [DUR_W-1:0]       a_dur = '0;
   logic                   m_ready, a_ready, busy, cmd_done;
   logic [2:0]             motion_mode;
   logic [$clog2(DEPTH):0] level;
`ifdef MOTION_SCHED_ABORT_EN
   logic                   abort = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   motion_cmd_scheduler #(
      .TICK_MAX (TICK_MAX),
      .DEPTH    (DEPTH),
      .DUR_W    (DUR_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
`ifdef MOTION_SCHED_ABORT_EN
      .abort       (abort),
`endif
      .m_valid     (m_valid),
      .m_mode      (m_mode),
      .m_dur       (m_dur),
      .m_ready     (m_ready),
      .a_valid     (a_valid),
      .a_mode      (a_mode),
      .a_dur       (a_dur),
      .a_ready     (a_ready),
      .motion_mode (motion_mode),
      .busy        (busy),
      .cmd_done    (cmd_done),
      .level       (level)
   );

   always #5 clk = ~clk;

   // Reference model: a plain command queue plus a countdown of remaining cycles
   typedef struct {
      logic [2:0] mode;
      int         dur;
   } mcmd_t;

   mcmd_t      mq[$];
   logic [2:0] mdl_mode = STOP;
   bit         mdl_busy = 1'b0;
   bit         mdl_done = 1'b0;
   bit         mdl_fav_m = 1'b1;
   int         mdl_left = 0;

   function automatic bit abort_active();
`ifdef MOTION_SCHED_ABORT_EN
      return abort;
`else
      return 1'b0;
`endif
   endfunction

   function automatic void mdl_grant(output bit gm, output bit ga);
      gm = 1'b0;
      ga = 1'b0;
      if (mq.size() < DEPTH && !abort_active()) begin
         gm = m_valid && (!a_valid || mdl_fav_m);
         ga = a_valid && !gm;
      end
   endfunction

   always @(posedge clk or posedge reset) begin : model_blk
      mcmd_t c;
      bit    gm, ga;
      if (reset) begin
         mq.delete();
         mdl_mode  = STOP;
         mdl_busy  = 1'b0;
         mdl_done  = 1'b0;
         mdl_fav_m = 1'b1;
         mdl_left  = 0;
      end else begin
         mdl_grant(gm, ga);
         if (abort_active()) begin
            mq.delete();
            mdl_mode = STOP;
            mdl_busy = 1'b0;
            mdl_done = 1'b0;
            mdl_left = 0;
         end else begin
            mdl_done = 1'b0;
            if (mdl_busy) begin
               mdl_left--;
               if (mdl_left == 0) begin
                  mdl_done = 1'b1;
                  if (mq.size() > 0 && mq[0].dur != 0) begin
                     c = mq.pop_front();
                     mdl_mode = c.mode;
                     mdl_left = c.dur * PER;
                  end else begin
                     mdl_mode = STOP;
                     mdl_busy = 1'b0;
                  end
               end
            end else if (mq.size() > 0) begin
               c = mq.pop_front();
               if (c.dur != 0) begin
                  mdl_mode = c.mode;
                  mdl_left = c.dur * PER;
                  mdl_busy = 1'b1;
               end
            end
            if (gm) begin
               c.mode = (m_mode == 3'b111) ? STOP : m_mode;
               c.dur  = int'(m_dur);
               mq.push_back(c);
               mdl_fav_m = 1'b0;
            end else if (ga) begin
               c.mode = (a_mode == 3'b111) ? STOP : a_mode;
               c.dur  = int'(a_dur);
               mq.push_back(c);
               mdl_fav_m = 1'b1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle, away from the rising edge, compare all outputs with the model
   always @(negedge clk) begin : cmp_blk
      bit gm, ga;
      #2;
      mdl_grant(gm, ga);
      checkOutput("m_ready", m_ready, gm);
      checkOutput("a_ready", a_ready, ga);
      checkOutput("motion_mode", motion_mode, mdl_mode);
      checkOutput("busy", busy, mdl_busy);
      checkOutput("cmd_done", cmd_done, mdl_done);
      checkOutput("level", level, mq.size());
   end

   task automatic applyStimulus(input bit mv, input logic [2:0] mm, input int md,
                                input bit av, input logic [2:0] am, input int ad);
      m_valid = mv;
      m_mode  = mm;
      m_dur   = DUR_W'(md);
      a_valid = av;
      a_mode  = am;
      a_dur   = DUR_W'(ad);
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, STOP, 0, 1'b0, STOP, 0);
   endtask

   task automatic doReset();
      @(negedge clk);
      idleInputs();
      #1 reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic watch(input int n, input logic [2:0] m, output int mode_cnt,
                        output int other_cnt, output int done_cnt, output int busy_cnt);
      mode_cnt  = 0;
      other_cnt = 0;
      done_cnt  = 0;
      busy_cnt  = 0;
      repeat (n) begin
         @(negedge clk);
         #3;
         if (motion_mode === m) mode_cnt++;
         else if (motion_mode !== STOP) other_cnt++;
         if (cmd_done === 1'b1) done_cnt++;
         if (busy === 1'b1) busy_cnt++;
      end
   endtask

   initial begin
      int  mc, oc, dc, bc;
      bit  found;

      repeat (3) @(negedge clk);
      #3;
      checkOutput("rst_mode", motion_mode, STOP);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", cmd_done, 0);
      checkOutput("rst_level", level, 0);
      #1 reset = 1'b0;

      // Single manual command R_1X for 3 ticks
      @(negedge clk);
      applyStimulus(1'b1, R_1X, 3, 1'b0, STOP, 0);
      #3 checkOutput("t1_m_ready", m_ready, 1);
      @(negedge clk);
      idleInputs();
      watch(30, R_1X, mc, oc, dc, bc);
      checkOutput("t1_hold", mc, 15);
      checkOutput("t1_other", oc, 0);
      checkOutput("t1_done", dc, 1);
      checkOutput("t1_busy", bc, 15);
      checkOutput("t1_end_mode", motion_mode, STOP);

      // Both requesters continuously valid from reset
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(1'b1, L_2X, 1, 1'b1, FWD, 2);
      @(negedge clk);
      #1 reset = 1'b0;
      #2;
      checkOutput("t2_first_m", m_ready, 1);
      checkOutput("t2_first_a", a_ready, 0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         #3;
         if (motion_mode !== STOP) found = 1'b1;
      end
      checkOutput("t2_started", found, 1);
      checkOutput("t2_first_mode", motion_mode, L_2X);
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         #3;
         if (i == 4)  checkOutput("t2_l2x_end", motion_mode, L_2X);
         if (i == 5)  checkOutput("t2_fwd_start", motion_mode, FWD);
         if (i == 14) checkOutput("t2_fwd_end", motion_mode, FWD);
         if (i == 15) checkOutput("t2_l2x_again", motion_mode, L_2X);
      end

      // Fill the FIFO and hold a further request
      doReset();
      applyStimulus(1'b1, FWD, 2, 1'b0, STOP, 0);
      repeat (5) @(negedge clk);
      #3;
      checkOutput("t3_full_level", level, 4);
      checkOutput("t3_full_ready", m_ready, 0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         #3;
         if (level === 3) found = 1'b1;
      end
      checkOutput("t3_drained", found, 1);
      checkOutput("t3_ready_again", m_ready, 1);
      @(negedge clk);
      idleInputs();
      repeat (60) @(negedge clk);

      // Zero-duration entry is dropped silently
      doReset();
      applyStimulus(1'b1, REV, 0, 1'b0, STOP, 0);
      @(negedge clk);
      applyStimulus(1'b1, R_2X, 1, 1'b0, STOP, 0);
      @(negedge clk);
      idleInputs();
      watch(20, R_2X, mc, oc, dc, bc);
      checkOutput("t4_r2x", mc, 5);
      checkOutput("t4_no_rev", oc, 0);
      checkOutput("t4_done", dc, 1);

      // Mode 111 runs as STOP but still occupies a full tick
      doReset();
      applyStimulus(1'b1, 3'b111, 1, 1'b0, STOP, 0);
      @(negedge clk);
      idleInputs();
      watch(15, R_1X, mc, oc, dc, bc);
      checkOutput("t5_motion", mc + oc, 0);
      checkOutput("t5_busy", bc, 5);
      checkOutput("t5_done", dc, 1);

      // Reset while running with commands queued
      doReset();
      applyStimulus(1'b1, FWD, 3, 1'b0, STOP, 0);
      repeat (4) @(negedge clk);
      idleInputs();
      repeat (6) @(negedge clk);
      #3;
      checkOutput("t6_pre_mode", motion_mode, FWD);
      checkOutput("t6_pre_level", level, 3);
      @(negedge clk);
      #1 reset = 1'b1;
      #2;
      checkOutput("t6_rst_mode", motion_mode, STOP);
      checkOutput("t6_rst_level", level, 0);
      @(negedge clk);
      #1 reset = 1'b0;
      watch(25, FWD, mc, oc, dc, bc);
      checkOutput("t6_after", mc + oc + bc, 0);

`ifdef MOTION_SCHED_ABORT_EN
      applyStimulus(1'b1, REV, 3, 1'b0, STOP, 0);
      repeat (4) @(negedge clk);
      idleInputs();
      repeat (6) @(negedge clk);
      abort = 1'b1;
      #3;
      checkOutput("t7_abort_ready", m_ready, 0);
      @(negedge clk);
      abort = 1'b0;
      #3;
      checkOutput("t7_abort_mode", motion_mode, STOP);
      checkOutput("t7_abort_level", level, 0);
      checkOutput("t7_abort_busy", busy, 0);
      checkOutput("t7_abort_done", cmd_done, 0);
      watch(25, REV, mc, oc, dc, bc);
      checkOutput("t7_after", mc + oc + bc + dc, 0);
`endif

      // Randomized traffic against the model
      doReset();
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         applyStimulus(($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), $urandom_range(0, 3),
                       ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), $urandom_range(0, 3));
`ifdef MOTION_SCHED_ABORT_EN
         abort = ($urandom_range(0, 39) == 0);
`endif
      end
      @(negedge clk);
      idleInputs();
`ifdef MOTION_SCHED_ABORT_EN
      abort = 1'b0;
`endif
      repeat (80) @(negedge clk);
      #5;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
